// File: rtl/iot_filter_gen.sv
// Serial-in IoT sample filter: assembles IN_W-bit beats into DATA_W-bit samples and
// applies a selectable per-sample or per-round function (pass, extrema, average, window, peak).
module iot_filter_gen #(
    parameter  int IN_W     = 8,
    parameter  int BEATS    = 16,
    parameter  int ROUND_LG = 3,
    localparam int DATA_W   = IN_W * BEATS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_en,
    input  logic [IN_W-1:0]   iot_in,
    input  logic [2:0]        fn_sel,
    input  logic [DATA_W-1:0] lo_bound,
    input  logic [DATA_W-1:0] hi_bound,
    output logic              busy,
    output logic              valid,
    output logic [DATA_W-1:0] iot_out
);
    localparam int CNT_W = $clog2(BEATS);
    localparam int SUM_W = DATA_W + ROUND_LG;

    typedef enum logic [1:0] {COLLECT, PROC, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic [2:0]          fn_q, fn_d;
    logic                restart_q, restart_d;
    logic [DATA_W-1:0]   lo_q, lo_d, hi_q, hi_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic [ROUND_LG-1:0] smp_cnt_q, smp_cnt_d;
    logic [DATA_W-1:0]   max_q, max_d, min_q, min_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [DATA_W-1:0]   pk_max_q, pk_max_d, pk_min_q, pk_min_d;
    logic                pk_seen_q, pk_seen_d;

    // A function change makes the current sample behave as sample 0 of a fresh round.
    logic [ROUND_LG-1:0] cnt_eff;
    logic                first, round_end, seen_eff;
    logic [DATA_W-1:0]   run_max, run_min;
    logic [SUM_W-1:0]    run_sum;

    always_comb begin
        cnt_eff   = restart_q ? '0 : smp_cnt_q;
        first     = (cnt_eff == '0);
        round_end = &cnt_eff;
        seen_eff  = restart_q ? 1'b0 : pk_seen_q;
        run_max   = (first || buf_q > max_q) ? buf_q : max_q;
        run_min   = (first || buf_q < min_q) ? buf_q : min_q;
        run_sum   = (first ? '0 : sum_q) + SUM_W'(buf_q);

        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        buf_d      = buf_q;
        fn_d       = fn_q;
        restart_d  = restart_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
        out_d      = out_q;
        smp_cnt_d  = smp_cnt_q;
        max_d      = max_q;
        min_d      = min_q;
        sum_d      = sum_q;
        pk_max_d   = pk_max_q;
        pk_min_d   = pk_min_q;
        pk_seen_d  = pk_seen_q;

        case (state_q)
            COLLECT: begin
                if (in_en) begin
                    buf_d      = {buf_q[DATA_W-IN_W-1:0], iot_in};
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == CNT_W'(BEATS - 2))
                        busy_d = 1'b1;
                    if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
                        fn_d       = fn_sel;
                        restart_d  = (fn_sel != fn_q);
                        lo_d       = lo_bound;
                        hi_d       = hi_bound;
                        beat_cnt_d = '0;
                        state_d    = PROC;
                    end
                end
            end
            PROC: begin
                state_d   = FLUSH;
                smp_cnt_d = cnt_eff + ROUND_LG'(1);
                max_d     = run_max;
                min_d     = run_min;
                sum_d     = run_sum;
                pk_seen_d = seen_eff;
                valid_d   = 1'b0;
                case (fn_q)
                    3'd0: begin
                        valid_d = 1'b1;
                        out_d   = buf_q;
                    end
                    3'd1: if (round_end) begin
                        valid_d = 1'b1;
                        out_d   = run_max;
                    end
                    3'd2: if (round_end) begin
                        valid_d = 1'b1;
                        out_d   = run_min;
                    end
                    3'd3: if (round_end) begin
                        valid_d = 1'b1;
                        out_d   = run_sum[SUM_W-1:ROUND_LG];
                    end
                    3'd4: if (buf_q > lo_q && buf_q < hi_q) begin
                        valid_d = 1'b1;
                        out_d   = buf_q;
                    end
                    3'd5: if (buf_q < lo_q || buf_q > hi_q) begin
                        valid_d = 1'b1;
                        out_d   = buf_q;
                    end
                    3'd6: if (round_end && (!seen_eff || run_max > pk_max_q)) begin
                        valid_d   = 1'b1;
                        out_d     = run_max;
                        pk_max_d  = run_max;
                        pk_seen_d = 1'b1;
                    end
                    3'd7: if (round_end && (!seen_eff || run_min < pk_min_q)) begin
                        valid_d   = 1'b1;
                        out_d     = run_min;
                        pk_min_d  = run_min;
                        pk_seen_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            FLUSH: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                buf_d   = '0;
                state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= COLLECT;
            beat_cnt_q <= '0;
            buf_q      <= '0;
            fn_q       <= '0;
            restart_q  <= 1'b0;
            lo_q       <= '0;
            hi_q       <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            out_q      <= '0;
            smp_cnt_q  <= '0;
            max_q      <= '0;
            min_q      <= '1;
            sum_q      <= '0;
            pk_max_q   <= '0;
            pk_min_q   <= '1;
            pk_seen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            buf_q      <= buf_d;
            fn_q       <= fn_d;
            restart_q  <= restart_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            out_q      <= out_d;
            smp_cnt_q  <= smp_cnt_d;
            max_q      <= max_d;
            min_q      <= min_d;
            sum_q      <= sum_d;
            pk_max_q   <= pk_max_d;
            pk_min_q   <= pk_min_d;
            pk_seen_q  <= pk_seen_d;
        end
    end

    assign busy    = busy_q;
    assign valid   = valid_q;
    assign iot_out = out_q;

endmodule

// File: tb/tb_iot_filter_gen.sv
// Directed scoreboard bench for iot_filter_gen: expected results are queued when a sample
// is driven and popped whenever the filter strobes valid.
module tb_iot_filter_gen;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_en = 1'b0;
    logic [7:0]   iot_in = '0;
    logic [2:0]   fn_sel = '0;
    logic [127:0] lo_bound = '0;
    logic [127:0] hi_bound = '0;
    logic         busy, valid;
    logic [127:0] iot_out;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [127:0] exp_q[$];
    logic [127:0] exp_out = '0;
    int           shuf[8] = '{3, 7, 1, 8, 5, 2, 6, 4};

    iot_filter_gen dut (
        .clk(clk), .rst(rst), .in_en(in_en), .iot_in(iot_in), .fn_sel(fn_sel),
        .lo_bound(lo_bound), .hi_bound(hi_bound),
        .busy(busy), .valid(valid), .iot_out(iot_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at each falling edge while a sample is in flight.
    task automatic watch(input string tag);
        if (valid === 1'b1) begin
            if (exp_q.size() == 0)
                check({tag, "_spurious_valid"}, 128'(valid), 128'd0);
            else
                check({tag, "_data"}, iot_out, exp_q.pop_front());
        end
    endtask

    task automatic send(input logic [127:0] d, input logic [2:0] fn, input logic ev,
                        input logic [127:0] ed, input string tag);
        fn_sel = fn;
        if (ev) exp_q.push_back(ed);
        for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            watch(tag);
            in_en  = 1'b1;
            iot_in = d[127-8*b -: 8];
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_en = 1'b0;
            watch(tag);
        end
        check({tag, "_missing_valid"}, 128'(exp_q.size()), 128'd0);
        exp_q.delete();
        if (ev) exp_out = ed;
        check({tag, "_out_held"}, iot_out, exp_out);
        check({tag, "_busy_idle"}, 128'(busy), 128'd0);
        $display("[TB] sample %s fn=%0d data=%h expect_valid=%0d iot_out=%h", tag, fn, d, ev, iot_out);
    endtask

    task automatic peak_round(input logic [2:0] fn, input int m, input logic ev, input string tag);
        for (int i = 0; i < 8; i++) begin
            int v;
            v = (i == 3) ? m : ((fn == 3'd6) ? (i % 3 + 1) : (20 + i));
            send(128'(v), fn, ev && (i == 7), 128'(m), tag);
        end
    endtask

    initial begin
        logic [127:0] hs;
        logic [127:0] big;
        hs  = 128'h0123456789ABCDEF_FEDCBA9876543210;
        big = 128'd1 << 127;

        #1;
        check("reset_busy",  128'(busy),  128'd0);
        check("reset_valid", 128'(valid), 128'd0);
        check("reset_out",   iot_out,     128'd0);
        @(negedge clk);
        rst = 1'b0;

        // Handshake: busy timing, latency and a beat dropped while busy.
        fn_sel = 3'd0;
        for (int b = 0; b < 15; b++) begin
            @(negedge clk);
            if (b == 14) check("hs_busy_before_b14", 128'(busy), 128'd0);
            in_en  = 1'b1;
            iot_in = hs[127-8*b -: 8];
        end
        @(negedge clk);
        check("hs_busy_after_b14", 128'(busy), 128'd1);
        iot_in = hs[7:0];
        @(negedge clk);
        check("hs_proc_valid", 128'(valid), 128'd0);
        check("hs_proc_busy",  128'(busy),  128'd1);
        iot_in = 8'hFF;
        @(negedge clk);
        in_en = 1'b0;
        check("hs_flush_valid", 128'(valid), 128'd1);
        check("hs_flush_data",  iot_out,     hs);
        check("hs_flush_busy",  128'(busy),  128'd1);
        @(negedge clk);
        check("hs_end_valid", 128'(valid), 128'd0);
        check("hs_end_busy",  128'(busy),  128'd0);
        exp_out = hs;
        $display("[TB] handshake fn=0 data=%h", hs);
        send(128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 3'd0, 1'b1,
             128'hA5A5_0000_1111_2222_3333_4444_5555_6666, "pass_after_drop");

        // Reset after five beats discards the partial sample.
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            in_en  = 1'b1;
            iot_in = 8'h3C;
        end
        @(negedge clk);
        in_en = 1'b0;
        rst   = 1'b1;
        #1;
        check("midrst_busy",  128'(busy),  128'd0);
        check("midrst_valid", 128'(valid), 128'd0);
        check("midrst_out",   iot_out,     128'd0);
        exp_out = '0;
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset after 5 beats");
        send(128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D, 3'd0, 1'b1,
             128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D, "pass_after_rst");

        // Max round, then a switch to min after three samples restarts the round.
        for (int i = 0; i < 8; i++) send(128'(shuf[i]), 3'd1, i == 7, 128'd8, "max");
        send(128'd5, 3'd1, 1'b0, 128'd0, "max_part");
        send(128'd9, 3'd1, 1'b0, 128'd0, "max_part");
        send(128'd2, 3'd1, 1'b0, 128'd0, "max_part");
        for (int i = 0; i < 8; i++) send(128'(shuf[i]), 3'd2, i == 7, 128'd1, "min");

        // Average: wide sum must not overflow.
        for (int i = 0; i < 8; i++)
            send((i == 3) ? 128'd7 : big, 3'd3, i == 7, 128'h7 << 124, "avg_big");
        for (int i = 0; i < 8; i++)
            send('1, 3'd3, i == 7, '1, "avg_ones");

        // Window functions with exclusive bounds.
        lo_bound = {4'h6, {124{1'b1}}};
        hi_bound = {4'hA, {124{1'b1}}};
        send(lo_bound, 3'd4, 1'b0, 128'd0, "ext_eq_lo");
        send(lo_bound, 3'd5, 1'b0, 128'd0, "exc_eq_lo");
        send(big,      3'd4, 1'b1, big,    "ext_mid");
        send(big,      3'd5, 1'b0, 128'd0, "exc_mid");
        send(hi_bound, 3'd5, 1'b0, 128'd0, "exc_eq_hi");
        send(hi_bound, 3'd4, 1'b0, 128'd0, "ext_eq_hi");
        send('1,       3'd5, 1'b1, '1,     "exc_above");
        send(128'd1,   3'd5, 1'b1, 128'd1, "exc_below");

        // Peak tracking across rounds.
        peak_round(3'd6, 10, 1'b1, "pkmax_r1");
        peak_round(3'd6,  9, 1'b0, "pkmax_r2");
        peak_round(3'd6, 12, 1'b1, "pkmax_r3");
        peak_round(3'd7,  5, 1'b1, "pkmin_r1");
        peak_round(3'd7,  5, 1'b0, "pkmin_r2");
        peak_round(3'd7,  3, 1'b1, "pkmin_r3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
